// File: rtl/step_coordinator.sv
`default_nettype none
// ============================================================================
// Module   : step_coordinator
// Brief    : Phase sequencer for the adaptive-step ODE datapath. It runs
//            FULL -> HALF -> EVAL -> UPDATE rounds, advances time, clips the
//            final step to tEnd and bounds rejected retries.
//            Optional EVAL watchdog: define STEP_COORD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module step_coordinator #(
    parameter int WIDTH        = 16,
    parameter int MAX_RETRY    = 8,
    parameter int EVAL_TIMEOUT = 64
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tEnd,
    input  logic [WIDTH-1:0] hInit,
    input  logic             odeDone,
    input  logic             stepFinish,
    input  logic             incTime,
    input  logic [WIDTH-1:0] hStepIn,
    input  logic             exceptionErr,
    output logic [1:0]       coord,
    output logic             odeReq,
    output logic [WIDTH-1:0] hOut,
    output logic [WIDTH-1:0] tOut,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       errCode
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FULL   = 3'd1,
        S_HALF   = 3'd2,
        S_EVAL   = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [2:0] c_ERR_NONE    = 3'b000;
    localparam logic [2:0] c_ERR_EXCEPT  = 3'b001;
    localparam logic [2:0] c_ERR_RETRY   = 3'b010;
    localparam logic [2:0] c_ERR_TIMEOUT = 3'b011;
    localparam logic [2:0] c_ERR_BAD_H   = 3'b100;
    localparam logic [2:0] c_ERR_T_OVF   = 3'b101;

    localparam int c_RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_LAST = c_RETRY_W'(MAX_RETRY - 1);

    state_t               r_state, w_stateNext;
    logic [WIDTH-1:0]     r_t, w_tNext;
    logic [WIDTH-1:0]     r_h, w_hNext;
    logic [WIDTH-1:0]     r_hNew, w_hNewNext;
    logic [WIDTH-1:0]     r_tEnd, w_tEndNext;
    logic [c_RETRY_W-1:0] r_retry, w_retryNext;
    logic [2:0]           r_errCode, w_errCodeNext;
    logic                 r_odeReq, w_odeReqNext;

    logic [WIDTH-1:0]     w_sum;
    logic                 w_sumOvf;
    logic [WIDTH-1:0]     w_room;
    logic                 w_startBad;
    logic                 w_timeout;

`ifdef STEP_COORD_TIMEOUT_EN
    localparam int c_EVAL_CNT_W = $clog2(EVAL_TIMEOUT + 1);
    localparam logic [c_EVAL_CNT_W-1:0] c_EVAL_LAST = c_EVAL_CNT_W'(EVAL_TIMEOUT - 1);

    logic [c_EVAL_CNT_W-1:0] r_evalCnt;

    // Held at zero outside EVAL, so every entry into EVAL starts a fresh count.
    always_ff @(posedge Clk) begin
        if (reset || (r_state != S_EVAL)) begin
            r_evalCnt <= '0;
        end else begin
            r_evalCnt <= r_evalCnt + c_EVAL_CNT_W'(1);
        end
    end

    assign w_timeout = (r_evalCnt == c_EVAL_LAST);
`else
    // Watchdog compiled out: EVAL waits on stepFinish indefinitely.
    assign w_timeout = (EVAL_TIMEOUT < 0);
`endif

    assign w_sum      = r_t + r_h;
    assign w_sumOvf   = (r_t[WIDTH-1] == r_h[WIDTH-1]) && (w_sum[WIDTH-1] != r_t[WIDTH-1]);
    assign w_room     = r_tEnd - r_t;
    assign w_startBad = hInit[WIDTH-1] | ~|hInit | tEnd[WIDTH-1] | ~|tEnd;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_t       <= '0;
            r_h       <= '0;
            r_hNew    <= '0;
            r_tEnd    <= '0;
            r_retry   <= '0;
            r_errCode <= c_ERR_NONE;
            r_odeReq  <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_t       <= w_tNext;
            r_h       <= w_hNext;
            r_hNew    <= w_hNewNext;
            r_tEnd    <= w_tEndNext;
            r_retry   <= w_retryNext;
            r_errCode <= w_errCodeNext;
            r_odeReq  <= w_odeReqNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_tNext       = r_t;
        w_hNext       = r_h;
        w_hNewNext    = r_hNew;
        w_tEndNext    = r_tEnd;
        w_retryNext   = r_retry;
        w_errCodeNext = r_errCode;

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    if (w_startBad) begin
                        w_stateNext   = S_ERR;
                        w_errCodeNext = c_ERR_BAD_H;
                    end else begin
                        w_stateNext   = S_FULL;
                        w_tNext       = '0;
                        w_hNext       = hInit;
                        w_tEndNext    = tEnd;
                        w_retryNext   = '0;
                        w_errCodeNext = c_ERR_NONE;
                    end
                end
            end
            S_FULL: begin
                if (exceptionErr) begin
                    w_stateNext   = S_ERR;
                    w_errCodeNext = c_ERR_EXCEPT;
                end else if (odeDone) begin
                    w_stateNext = S_HALF;
                end
            end
            S_HALF: begin
                if (exceptionErr) begin
                    w_stateNext   = S_ERR;
                    w_errCodeNext = c_ERR_EXCEPT;
                end else if (odeDone) begin
                    w_stateNext = S_EVAL;
                end
            end
            S_EVAL: begin
                if (exceptionErr) begin
                    w_stateNext   = S_ERR;
                    w_errCodeNext = c_ERR_EXCEPT;
                end else if (stepFinish) begin
                    w_hNewNext = hStepIn;
                    if (incTime) begin
                        if (w_sumOvf) begin
                            w_stateNext   = S_ERR;
                            w_errCodeNext = c_ERR_T_OVF;
                        end else begin
                            w_stateNext = S_UPDATE;
                            w_tNext     = w_sum;
                            w_retryNext = '0;
                        end
                    end else begin
                        w_retryNext = r_retry + c_RETRY_W'(1);
                        if (r_retry == c_RETRY_LAST) begin
                            w_stateNext   = S_ERR;
                            w_errCodeNext = c_ERR_RETRY;
                        end else begin
                            w_stateNext = S_UPDATE;
                        end
                    end
                end else if (w_timeout) begin
                    w_stateNext   = S_ERR;
                    w_errCodeNext = c_ERR_TIMEOUT;
                end
            end
            S_UPDATE: begin
                if (exceptionErr) begin
                    w_stateNext   = S_ERR;
                    w_errCodeNext = c_ERR_EXCEPT;
                end else if ($signed(r_t) >= $signed(r_tEnd)) begin
                    w_stateNext = S_DONE;
                end else if (r_hNew[WIDTH-1] || (r_hNew == '0)) begin
                    w_stateNext   = S_ERR;
                    w_errCodeNext = c_ERR_BAD_H;
                end else begin
                    // Clip so the last step lands exactly on tEnd.
                    w_stateNext = S_FULL;
                    w_hNext     = ($signed(r_hNew) < $signed(w_room)) ? r_hNew : w_room;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase

        w_odeReqNext = ((w_stateNext == S_FULL) || (w_stateNext == S_HALF)) &&
                       (w_stateNext != r_state);
    end

    always_comb begin
        coord = 2'b01;
        busy  = 1'b0;
        done  = 1'b0;
        error = 1'b0;
        case (r_state)
            S_FULL:   begin coord = 2'b00; busy = 1'b1; end
            S_HALF:   begin coord = 2'b10; busy = 1'b1; end
            S_EVAL:   begin coord = 2'b11; busy = 1'b1; end
            S_UPDATE: busy  = 1'b1;
            S_DONE:   done  = 1'b1;
            S_ERR:    error = 1'b1;
            default:  coord = 2'b01;
        endcase
    end

    assign odeReq  = r_odeReq;
    assign hOut    = r_h;
    assign tOut    = r_t;
    assign errCode = r_errCode;

endmodule
`default_nettype wire

// File: tb/tb_step_coordinator.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_coordinator
// Brief    : Self-checking bench for step_coordinator: table-driven runs with
//            an hOut/result scoreboard plus hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_coordinator;

    logic        Clk = 1'b0;
    logic        reset, start, odeDone, stepFinish, incTime, exceptionErr;
    logic [15:0] tEnd, hInit, hStepIn;
    logic [1:0]  coord;
    logic        odeReq, busy, done, error;
    logic [15:0] hOut, tOut;
    logic [2:0]  errCode;

    int nChecks = 0;
    int nFails  = 0;

    step_coordinator #(.WIDTH(16), .MAX_RETRY(4), .EVAL_TIMEOUT(64)) dut (
        .Clk(Clk), .reset(reset), .start(start), .tEnd(tEnd), .hInit(hInit),
        .odeDone(odeDone), .stepFinish(stepFinish), .incTime(incTime),
        .hStepIn(hStepIn), .exceptionErr(exceptionErr), .coord(coord),
        .odeReq(odeReq), .hOut(hOut), .tOut(tOut), .busy(busy), .done(done),
        .error(error), .errCode(errCode)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] hInit, tEnd, hStep;
        logic        accept;
        logic        expDone, expErr;
        logic [2:0]  expCode;
        logic [15:0] expT;
    } vec_t;

    typedef struct {
        logic        done, err;
        logic [2:0]  code;
        logic [15:0] t;
    } res_t;

    vec_t        vecs[6];
    res_t        resQ[$];
    logic [15:0] hQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected step sequence seen on hOut at each FULL entry.
    task automatic pushHSeq(input vec_t v);
        int t, h, hs, te, retry;
        t = 0; h = $signed(v.hInit); hs = $signed(v.hStep); te = $signed(v.tEnd); retry = 0;
        for (int k = 0; k < 20; k++) begin
            hQ.push_back(h[15:0]);
            if (v.accept) begin
                t = t + h;
                if (t >= te) break;
            end else begin
                retry++;
                if (retry >= 4) break;
            end
            if (hs <= 0) break;
            h = (hs < te - t) ? hs : te - t;
        end
    endtask

    task automatic startRun(input logic [15:0] h, input logic [15:0] te);
        hInit = h; tEnd = te; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic runVec(input int idx, input vec_t v);
        res_t exp, got;
        bit   finished = 0;
        pushHSeq(v);
        exp.done = v.expDone; exp.err = v.expErr; exp.code = v.expCode; exp.t = v.expT;
        resQ.push_back(exp);
        startRun(v.hInit, v.tEnd);
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (done || error) begin
                finished = 1;
                break;
            end
            if (coord == 2'b00 && odeReq) begin
                if (hQ.size() == 0) check($sformatf("v%0d_extraRound", idx), 32'd1, 32'd0);
                else                check($sformatf("v%0d_hOut", idx), hOut, hQ.pop_front());
            end
            odeDone    = (coord == 2'b00) || (coord == 2'b10);
            stepFinish = (coord == 2'b11);
            incTime    = v.accept;
            hStepIn    = v.hStep;
            @(negedge Clk);
        end
        odeDone = 0; stepFinish = 0; incTime = 0;
        check($sformatf("v%0d_finished", idx), finished, 1);
        check($sformatf("v%0d_roundsLeft", idx), hQ.size(), 0);
        hQ.delete();
        got.done = done; got.err = error; got.code = errCode; got.t = tOut;
        exp = resQ.pop_front();
        check($sformatf("v%0d_done", idx), got.done, exp.done);
        check($sformatf("v%0d_error", idx), got.err, exp.err);
        check($sformatf("v%0d_errCode", idx), got.code, exp.code);
        check($sformatf("v%0d_tOut", idx), got.t, exp.t);
    endtask

    task automatic toEval();
        odeDone = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        odeDone = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h0100, 16'h0300, 16'h0100, 1'b1, 1'b1, 1'b0, 3'b000, 16'h0300};
        vecs[1] = '{16'h0200, 16'h0300, 16'h0200, 1'b1, 1'b1, 1'b0, 3'b000, 16'h0300};
        vecs[2] = '{16'h0100, 16'h0300, 16'h0100, 1'b0, 1'b0, 1'b1, 3'b010, 16'h0000};
        vecs[3] = '{16'h0080, 16'h0100, 16'h0040, 1'b1, 1'b1, 1'b0, 3'b000, 16'h0100};
        vecs[4] = '{16'h0100, 16'h0400, 16'hFF00, 1'b1, 1'b0, 1'b1, 3'b100, 16'h0100};
        vecs[5] = '{16'h0500, 16'h0300, 16'h0100, 1'b1, 1'b1, 1'b0, 3'b000, 16'h0500};

        reset = 1; start = 0; odeDone = 0; stepFinish = 0; incTime = 0;
        exceptionErr = 0; tEnd = 0; hInit = 0; hStepIn = 0;
        repeat (3) @(negedge Clk);
        reset = 0;
        check("rst_coord", coord, 2'b01);
        check("rst_odeReq", odeReq, 0);
        check("rst_hOut", hOut, 0);
        check("rst_tOut", tOut, 0);
        check("rst_flags", {busy, done, error}, 3'b000);
        check("rst_errCode", errCode, 0);

        // Bad initial step straight out of reset.
        startRun(16'hFF00, 16'h0300);
        check("badH_error", error, 1);
        check("badH_errCode", errCode, 3'b100);

        for (int i = 0; i < 6; i++) runVec(i, vecs[i]);

        // Exception during HALF.
        startRun(16'h0100, 16'h0300);
        check("full_coord", coord, 2'b00);
        check("full_odeReq", odeReq, 1);
        odeDone = 1;
        @(negedge Clk);
        check("half_coord", coord, 2'b10);
        check("half_odeReq", odeReq, 1);
        odeDone = 0; exceptionErr = 1;
        @(negedge Clk);
        exceptionErr = 0;
        check("excHalf_error", error, 1);
        check("excHalf_errCode", errCode, 3'b001);

        // stepFinish coincident with exception in EVAL.
        startRun(16'h0100, 16'h0300);
        check("restart_errCode", errCode, 3'b000);
        toEval();
        check("eval_coord", coord, 2'b11);
        check("eval_odeReq", odeReq, 0);
        stepFinish = 1; incTime = 1; hStepIn = 16'h0100; exceptionErr = 1;
        @(negedge Clk);
        stepFinish = 0; incTime = 0; exceptionErr = 0;
        check("excEval_error", error, 1);
        check("excEval_errCode", errCode, 3'b001);
        check("excEval_tOut", tOut, 16'h0000);

        // Start while busy is ignored, then reset aborts from EVAL.
        startRun(16'h0100, 16'h0300);
        hInit = 16'h0700; start = 1;
        @(negedge Clk);
        start = 0;
        check("busyStart_coord", coord, 2'b00);
        check("busyStart_hOut", hOut, 16'h0100);
        check("busyStart_odeReq", odeReq, 0);
        toEval();
        stepFinish = 1; incTime = 1; hStepIn = 16'h0100;
        @(negedge Clk);
        stepFinish = 0; incTime = 0;
        check("update_tOut", tOut, 16'h0100);
        check("update_coord", coord, 2'b01);
        @(negedge Clk);
        check("round2_odeReq", odeReq, 1);
        toEval();
        reset = 1;
        @(negedge Clk);
        reset = 0;
        check("abort_coord", coord, 2'b01);
        check("abort_busy", busy, 0);
        check("abort_tOut", tOut, 16'h0000);

        // Non-positive end time.
        startRun(16'h0100, 16'h0000);
        check("badTEnd_errCode", errCode, 3'b100);

        // EVAL with no verdict.
        startRun(16'h0100, 16'h0300);
        toEval();
`ifdef STEP_COORD_TIMEOUT_EN
        repeat (63) @(negedge Clk);
        check("preTimeout_coord", coord, 2'b11);
        @(negedge Clk);
        check("timeout_error", error, 1);
        check("timeout_errCode", errCode, 3'b011);
`else
        repeat (199) @(negedge Clk);
        check("noTimeout_coord", coord, 2'b11);
        check("noTimeout_error", error, 0);
`endif
        reset = 1;
        @(negedge Clk);
        reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
